// File: rtl/norm2_pkg.sv
// Shared constants and state type for the norm2 job sequencer.
// The kernel array is N deep; a job of cnt elements occupies addresses N-cnt .. N-1.
package norm2_pkg;

    localparam int N  = 1000;
    localparam int AW = 10;
    localparam int DW = 27;
    localparam int RW = 64;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        RUN,
        RESP
    } seq_state_t;

    // First array address of a job; counts above N clamp to N.
    function automatic logic [AW-1:0] base_of(input logic [AW:0] count);
        logic [AW:0] lim;
        logic [AW:0] c;
        lim = N[AW:0];
        c = (count > lim) ? lim : count;
        return AW'(lim - c);
    endfunction

endpackage

// File: rtl/norm2_job_sequencer.sv
// Runs one sum-of-squares job on the norm2 kernel: load operands into the
// kernel array, release the kernel, then return its result with a watchdog.
module norm2_job_sequencer
    import norm2_pkg::*;
#(
    parameter int TIMEOUT = 16384
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          job_valid,
    output logic          job_ready,
    input  logic [AW:0]   job_count,
    input  logic [RW-1:0] job_acc,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [DW-1:0] ld_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [RW-1:0] rsp_result,
    output logic          rsp_err,
    output logic          k_r_enable,
    output logic          k_ctrl_arr,
    output logic [AW-1:0] k_init_i,
    output logic [RW-1:0] k_init_acc,
    output logic          k_arr_we,
    output logic [AW-1:0] k_arr_addr,
    output logic [DW-1:0] k_arr_wdata,
    input  logic          k_w_enable,
    input  logic [RW-1:0] k_result
);

    localparam int WW = $clog2(TIMEOUT);

    seq_state_t    state;
    seq_state_t    state_n;
    logic [AW-1:0] addr;
    logic [WW-1:0] wdog;
    logic          job_hs;
    logic          ld_hs;
    logic          rsp_hs;
    logic          wdog_exp;

    assign job_hs   = job_valid & job_ready;
    assign ld_hs    = ld_valid & ld_ready;
    assign rsp_hs   = rsp_valid & rsp_ready;
    assign wdog_exp = (wdog == WW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (job_hs) state_n = (job_count != '0) ? LOAD : START;
            LOAD:  if (ld_hs && addr == AW'(N - 1)) state_n = START;
            START: state_n = RUN;
            RUN:   if (k_w_enable || wdog_exp) state_n = RESP;
            RESP:  if (rsp_hs) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Handshake and kernel-control outputs are registered copies of the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            job_ready   <= 1'b1;
            ld_ready    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_result  <= '0;
            k_r_enable  <= 1'b1;
            k_ctrl_arr  <= 1'b1;
            k_arr_we    <= 1'b0;
            k_arr_addr  <= '0;
            k_arr_wdata <= '0;
            k_init_i    <= AW'(N);
            k_init_acc  <= '0;
            addr        <= '0;
            wdog        <= '0;
        end else begin
            job_ready  <= (state_n == IDLE);
            ld_ready   <= (state_n == LOAD);
            rsp_valid  <= (state_n == RESP);
            k_r_enable <= (state_n != RUN);
            k_ctrl_arr <= (state_n != RUN);
            k_arr_we   <= 1'b0;
            if (job_hs) begin
                k_init_i   <= base_of(job_count);
                k_init_acc <= job_acc;
                addr       <= base_of(job_count);
            end
            if (ld_hs) begin
                k_arr_we    <= 1'b1;
                k_arr_addr  <= addr;
                k_arr_wdata <= ld_data;
                addr        <= addr + 1'b1;
            end
            if (state == START)    wdog <= '0;
            else if (state == RUN) wdog <= wdog + 1'b1;
            if (state == RUN) begin
                if (k_w_enable) begin
                    rsp_result <= k_result;
                    rsp_err    <= 1'b0;
                end else if (wdog_exp) begin
                    rsp_result <= '0;
                    rsp_err    <= 1'b1;
                end
            end
        end
    end

endmodule
